// File: rtl/yfilter.sv
// Vertical 1-2-1 stage of the 3x3 low-pass filter: two line buffers plus a row/column
// sequencer that emits one vertical-sum beat per column and the column/row flags for the x filter.
module yfilter #(
   parameter int XB    = 10,
   parameter int YB    = 10,
   parameter int PB    = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [PB-1:0] i_pixel,
   output logic          o_ready,
   output logic          o_valid_new_pixel,
   output logic [PB+1:0] o_new_pixel,
   output logic          o_valid_lpos,
   output logic          o_valid_cpos,
   output logic          o_valid_rpos,
   output logic          o_rowM
);

   localparam logic [XB-1:0] LAST_COL = XB'(IMG_W - 1);
   localparam logic [YB-1:0] LAST_ROW = YB'(IMG_H - 1);

   typedef enum logic [1:0] {S_FILL, S_RUN, S_EOL, S_DRAIN} state_t;
   typedef enum logic [1:0] {M_ROW1, M_MID, M_DRAIN} mode_t;

   state_t        r_state;
   logic [XB-1:0] r_col;
   logic [YB-1:0] r_row;
   logic          r_ready;
   logic          r_drain_flush;

   // Issue stage: describes the beat whose line-buffer read is in flight.
   logic          r_s1_np, r_s1_l, r_s1_c, r_s1_r, r_s1_m;
   mode_t         r_s1_mode;
   logic [PB-1:0] r_s1_pix;

   logic [PB-1:0] r_lb_old [2**XB];
   logic [PB-1:0] r_lb_new [2**XB];
   logic [PB-1:0] r_rd_old, r_rd_new;

   logic          r_out_np, r_out_l, r_out_c, r_out_r, r_out_m;
   logic [PB+1:0] r_out_pix;

   logic          w_accept;
   logic [PB+1:0] w_old, w_new, w_cur, w_sum;

   assign w_accept = i_valid & r_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FILL;
         r_col         <= '0;
         r_row         <= '0;
         r_ready       <= 1'b0;
         r_drain_flush <= 1'b0;
         r_s1_np       <= 1'b0;
         r_s1_l        <= 1'b0;
         r_s1_c        <= 1'b0;
         r_s1_r        <= 1'b0;
         r_s1_m        <= 1'b0;
         r_s1_mode     <= M_MID;
         r_s1_pix      <= '0;
      end else begin
         // NOTE: pulse-type issue flags default low each cycle; only the active state raises them.
         r_s1_np       <= 1'b0;
         r_s1_l        <= 1'b0;
         r_s1_c        <= 1'b0;
         r_s1_r        <= 1'b0;
         r_s1_m        <= 1'b0;
         r_drain_flush <= 1'b0;
         case (r_state)
            S_FILL, S_RUN: begin
               r_ready <= 1'b1;
               // Flush beat of the previous frame's last row rides in the first FILL cycle.
               if (r_drain_flush) begin
                  r_s1_r <= 1'b1;
                  r_s1_m <= 1'b1;
               end
               if (w_accept) begin
                  if (r_state == S_RUN) begin
                     r_s1_np   <= 1'b1;
                     r_s1_l    <= (r_col == XB'(1));
                     r_s1_c    <= (r_col >= XB'(2));
                     r_s1_mode <= (r_row == YB'(1)) ? M_ROW1 : M_MID;
                     r_s1_pix  <= i_pixel;
                  end
                  if (r_col == LAST_COL) begin
                     r_col   <= '0;
                     r_ready <= 1'b0;
                     r_state <= S_EOL;
                  end else begin
                     r_col <= r_col + XB'(1);
                  end
               end
            end
            S_EOL: begin
               r_s1_r <= (r_row != '0);
               if (r_row == LAST_ROW) begin
                  r_row   <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_row   <= r_row + YB'(1);
                  r_ready <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_DRAIN: begin
               r_s1_np   <= 1'b1;
               r_s1_l    <= (r_col == XB'(1));
               r_s1_c    <= (r_col >= XB'(2));
               r_s1_m    <= (r_col != '0);
               r_s1_mode <= M_DRAIN;
               if (r_col == LAST_COL) begin
                  r_col         <= '0;
                  r_ready       <= 1'b1;
                  r_drain_flush <= 1'b1;
                  r_state       <= S_FILL;
               end else begin
                  r_col <= r_col + XB'(1);
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   // NOTE: line buffers carry no reset; row 0 of every frame overwrites whatever they hold.
   always_ff @(posedge clk) begin
      r_rd_old <= r_lb_old[r_col];
      r_rd_new <= r_lb_new[r_col];
      if (w_accept) begin
         r_lb_old[r_col] <= r_lb_new[r_col];
         r_lb_new[r_col] <= i_pixel;
      end
   end

   always_comb begin
      w_old = {2'b00, r_rd_old};
      w_new = {2'b00, r_rd_new};
      w_cur = {2'b00, r_s1_pix};
      w_sum = '0;
      case (r_s1_mode)
         M_ROW1:  w_sum = w_new + w_new + w_new + w_cur;
         M_MID:   w_sum = w_old + w_new + w_new + w_cur;
         M_DRAIN: w_sum = w_old + w_new + w_new + w_new;
         default: w_sum = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_np  <= 1'b0;
         r_out_l   <= 1'b0;
         r_out_c   <= 1'b0;
         r_out_r   <= 1'b0;
         r_out_m   <= 1'b0;
         r_out_pix <= '0;
      end else begin
         r_out_np  <= r_s1_np;
         r_out_l   <= r_s1_l;
         r_out_c   <= r_s1_c;
         r_out_r   <= r_s1_r;
         r_out_m   <= r_s1_m;
         r_out_pix <= r_s1_np ? w_sum : '0;
      end
   end

   assign o_ready           = r_ready;
   assign o_valid_new_pixel = r_out_np;
   assign o_new_pixel       = r_out_pix;
   assign o_valid_lpos      = r_out_l;
   assign o_valid_cpos      = r_out_c;
   assign o_valid_rpos      = r_out_r;
   assign o_rowM            = r_out_m;

endmodule

// File: tb/tb_yfilter.sv
// Self-checking bench for yfilter: frame-level model of the vertical 1-2-1 filter with
// replicated edges, checked beat by beat, plus o_ready stall counts and literal pins.
module tb_yfilter;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int XB = 3;
   localparam int YB = 2;
   localparam int PB = 8;

   typedef struct packed {
      logic       np;
      logic       l;
      logic       c;
      logic       r;
      logic       m;
      logic [9:0] v;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic [PB-1:0] i_pixel;
   logic          o_ready;
   logic          o_valid_new_pixel;
   logic [PB+1:0] o_new_pixel;
   logic          o_valid_lpos, o_valid_cpos, o_valid_rpos, o_rowM;

   int    tests = 0;
   int    fails = 0;
   int    img [H][W];
   beat_t exp_q[$];
   beat_t obs_q[$];

   yfilter #(.XB(XB), .YB(YB), .PB(PB), .IMG_W(W), .IMG_H(H)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_valid           (i_valid),
      .i_pixel           (i_pixel),
      .o_ready           (o_ready),
      .o_valid_new_pixel (o_valid_new_pixel),
      .o_new_pixel       (o_new_pixel),
      .o_valid_lpos      (o_valid_lpos),
      .o_valid_cpos      (o_valid_cpos),
      .o_valid_rpos      (o_valid_rpos),
      .o_rowM            (o_rowM)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected beats of one frame: output row y = top + 2*mid + bot, edges replicated.
   task automatic push_frame(input int limit);
      int n = 0;
      for (int y = 0; y < H; y++) begin
         int up = (y == 0) ? 0 : y - 1;
         int dn = (y == H - 1) ? H - 1 : y + 1;
         for (int c = 0; c <= W; c++) begin
            beat_t b;
            b = '0;
            if (c < W) begin
               b.np = 1'b1;
               b.l  = (c == 1);
               b.c  = (c >= 2);
               b.m  = (y == H - 1) && (c != 0);
               b.v  = 10'(img[up][c] + 2 * img[y][c] + img[dn][c]);
            end else begin
               b.r = 1'b1;
               b.m = (y == H - 1);
            end
            if (limit < 0 || n < limit) exp_q.push_back(b);
            n++;
         end
      end
   endtask

   always @(negedge clk) begin
      beat_t got;
      if (o_valid_new_pixel | o_valid_lpos | o_valid_cpos | o_valid_rpos) begin
         got = '{o_valid_new_pixel, o_valid_lpos, o_valid_cpos, o_valid_rpos, o_rowM, o_new_pixel};
         obs_q.push_back(got);
         if (exp_q.size() == 0) check("beat_expected", 32'(exp_q.size()), 1);
         else check("beat", 32'(got), 32'(exp_q.pop_front()));
      end else if (o_rowM || o_new_pixel != '0) begin
         check("idle_outputs", {o_rowM, o_new_pixel}, 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
      end
   endtask

   // Offers one pixel (with random bubbles) until accepted; counts cycles o_ready was low.
   task automatic send_pixel(input int p, input int gap_pct, output int low);
      int guard = 0;
      low = 0;
      forever begin
         @(negedge clk);
         if (!o_ready) low++;
         if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            i_valid = 1'b0;
         end else begin
            i_valid = 1'b1;
            i_pixel = p[7:0];
            if (o_ready) break;
         end
         guard++;
         if (guard > 200) begin
            check("accept_timeout", guard, 0);
            break;
         end
      end
   endtask

   task automatic send_frame(input int gap_pct, input int first_low, input int npix);
      int low;
      int k = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (k < npix) begin
               send_pixel(img[r][c], gap_pct, low);
               if (r == 0 && c == 0) begin
                  if (first_low >= 0) check("ready_low_frame", low, first_low);
               end else if (c == 0) begin
                  check("ready_low_row", low, 1);
               end else begin
                  check("ready_low_mid", low, 0);
               end
            end
            k++;
         end
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      @(negedge clk);
      i_valid = 1'b0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_done", 32'(exp_q.size()), 0);
      idle(4);
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
   endtask

   function automatic int count_val(input int v);
      int n = 0;
      foreach (obs_q[i]) if (obs_q[i].np && obs_q[i].v == 10'(v)) n++;
      return n;
   endfunction

   initial begin
      int nm;
      rst = 1'b1;
      i_valid = 1'b0;
      i_pixel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", o_ready, 0);
      check("rst_outputs", {o_valid_new_pixel, o_valid_lpos, o_valid_cpos, o_valid_rpos,
                            o_rowM, o_new_pixel}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", o_ready, 1);

      // Constant 100 then rows of 10*row, back to back.
      fill_const(100);
      push_frame(-1);
      send_frame(0, 0, W * H);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 10 * r;
      push_frame(-1);
      send_frame(0, W + 1, W * H);
      wait_drain();
      check("obs_count_ab", 32'(obs_q.size()), 30);
      check("a_first_sum", obs_q[0].v, 400);
      check("a_count_400", count_val(400), 12);
      check("a_flush_beat", 32'(obs_q[4]), 32'(beat_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0}));
      check("b_row0_sum", obs_q[15].v, 10);
      check("b_row1_sum", obs_q[20].v, 40);
      check("b_row2_sum", obs_q[26].v, 70);
      nm = 0;
      for (int i = 15; i < 30; i++) if (obs_q[i].m) nm++;
      check("b_rowm_beats", nm, 4);
      obs_q.delete();

      // Random pixels with random input bubbles.
      for (int f = 0; f < 4; f++) begin
         fill_rand();
         push_frame(-1);
         send_frame(30, (f == 0) ? 0 : W + 1, W * H);
      end
      wait_drain();
      check("obs_count_rand", 32'(obs_q.size()), 60);
      obs_q.delete();

      // Frame of 0s then frame of 255s back to back.
      fill_const(0);
      push_frame(-1);
      send_frame(0, 0, W * H);
      fill_const(255);
      push_frame(-1);
      send_frame(0, W + 1, W * H);
      wait_drain();
      check("count_1020", count_val(1020), 12);
      obs_q.delete();

      // Abort during row 1, then a fresh frame of 50s.
      fill_rand();
      push_frame(2);
      send_frame(0, 0, W + 2);
      idle(6);
      @(negedge clk);
      rst = 1'b1;
      i_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("abort_beats", 32'(obs_q.size()), 2);
      check("abort_queue", 32'(exp_q.size()), 0);
      obs_q.delete();
      fill_const(50);
      push_frame(-1);
      send_frame(0, 0, W * H);
      wait_drain();
      check("count_200", count_val(200), 12);
      check("obs_count_50", 32'(obs_q.size()), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
